// File: rtl/ifid_stage.sv
// IF/ID pipeline register with load-use stall detection, branch/jump squash,
// end-of-program halt and saturating stall/flush performance counters.
module ifid_stage #(
    parameter logic [31:0] NOP_WORD    = 32'h00000000,
    parameter logic [11:0] END_PATTERN = 12'h300,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instructionIn,
    input  logic [31:0]      pcPlus4In,
    input  logic             branchIn,
    input  logic             jumpIn,
    input  logic             idExMemRead,
    input  logic [4:0]       idExRd,
    output logic [31:0]      instructionId,
    output logic [31:0]      pcPlus4Id,
    output logic             validId,
    output logic             stallOut,
    output logic             redirectOk,
    output logic             halted,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    typedef enum logic [1:0] {RUN, HOLD, HALT} state_t;

    state_t      state;
    state_t      stateNext;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [5:0]  opcode;
    logic        usesRs2;
    logic        hazard;
    logic        endSeen;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Decode-side view of the instruction held in IF/ID
    assign rs1     = instructionId[25:21];
    assign rs2     = instructionId[20:16];
    assign opcode  = instructionId[31:26];
    assign usesRs2 = (opcode == 6'h00) | (opcode[5:3] == 3'b101);

    assign hazard = validId & idExMemRead & (idExRd != 5'd0) &
                    ((idExRd == rs1) | (usesRs2 & (idExRd == rs2)));

    assign stallOut   = hazard & (state != HALT);
    assign redirectOk = (branchIn | jumpIn) & validId & ~stallOut;
    assign endSeen    = validId & (instructionId[11:0] == END_PATTERN);
    assign halted     = (state == HALT);

    always_comb begin
        stateNext = state;
        if (state != HALT) begin
            if (endSeen)
                stateNext = HALT;
            else if (stallOut)
                stateNext = HOLD;
            else
                stateNext = RUN;
        end
    end

    // IF -> ID boundary: stall holds, redirect squashes, otherwise advance
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            instructionId <= NOP_WORD;
            pcPlus4Id     <= 32'h0;
            validId       <= 1'b0;
            stallCount    <= '0;
            flushCount    <= '0;
        end else begin
            state <= stateNext;
            if (state != HALT) begin
                if (endSeen) begin
                    validId <= 1'b0;
                end else if (stallOut) begin
                    stallCount <= satInc(stallCount);
                end else if (redirectOk) begin
                    instructionId <= NOP_WORD;
                    pcPlus4Id     <= pcPlus4In;
                    validId       <= 1'b0;
                    flushCount    <= satInc(flushCount);
                end else begin
                    instructionId <= instructionIn;
                    pcPlus4Id     <= pcPlus4In;
                    validId       <= 1'b1;
                end
            end
        end
    end

endmodule
